uart_icb_resp: RTL and testbench



---
 rtl/uart_icb_resp.sv | 153 +++++++++++++++
 tb/tb_uart_icb_resp.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_icb_resp.sv
// rtl/uart_icb_resp.sv - ICB register responder for the UART window with paced TX FIFO and RX FIFO; optional macro UART_ICB_RESP_ERR_EN flags unmapped accesses
module uart_icb_resp #(
  parameter int FIFO_DEPTH = 8,
  parameter int TX_GAP     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [31:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_byte,
  input  logic        rx_push,
  input  logic [7:0]  rx_byte,
  output logic        rx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(TX_GAP - 1);

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic          txen;
  logic [CW-1:0] gap_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          cmd_accept, hit_tx, hit_rx, hit_ctl, bad_addr;
  logic          tx_push, tx_pop, rx_pop, rx_wr;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  // Only the low 12 address bits and the low data byte carry meaning here.
  assign unused_bits = ^{icb_cmd_addr[31:12], icb_cmd_wdata[31:8]};

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  // One outstanding command: a new one may enter as the old response leaves.
  assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;

  assign hit_tx  = (icb_cmd_addr[11:0] == 12'h000);
  assign hit_rx  = (icb_cmd_addr[11:0] == 12'h004);
  assign hit_ctl = (icb_cmd_addr[11:0] == 12'h008);

`ifdef UART_ICB_RESP_ERR_EN
  assign bad_addr = ~(hit_tx | hit_rx | hit_ctl);
`else
  assign bad_addr = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  assign tx_pop  = txen & ~tx_empty & (gap_cnt == '0);
  assign tx_push = cmd_accept & ~icb_cmd_read & hit_tx & (~tx_full | tx_pop);
  assign rx_pop  = cmd_accept & icb_cmd_read & hit_rx & ~rx_empty;
  assign rx_wr   = rx_push & (~rx_full | rx_pop);

  // Read data is chosen from pre-pop state; a same-cycle RX push is not visible yet.
  always_comb begin
    rd_mux = 32'd0;
    if (icb_cmd_read) begin
      if (hit_tx)
        rd_mux = {tx_full, 31'd0};
      else if (hit_rx && !rx_empty)
        rd_mux = {1'b1, 23'd0, rx_mem[rx_rptr[AW-1:0]]};
      else if (hit_ctl)
        rd_mux = {31'd0, txen};
    end
  end

  // Response register: loads on accept, holds until the initiator takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= 32'd0;
      icb_rsp_err   <= 1'b0;
    end else if (cmd_accept) begin
      icb_rsp_valid <= 1'b1;
      icb_rsp_rdata <= rd_mux;
      icb_rsp_err   <= bad_addr;
    end else if (icb_rsp_ready) begin
      icb_rsp_valid <= 1'b0;
    end
  end

  // TX storage write port.
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wptr[AW-1:0]] <= icb_cmd_wdata[7:0];
  end

  // TX pointers, enable and paced drain; the gap counter runs down even while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr       <= '0;
      tx_rptr       <= '0;
      txen          <= 1'b0;
      gap_cnt       <= '0;
      tx_byte_valid <= 1'b0;
      tx_byte       <= 8'd0;
    end else begin
      if (tx_push)
        tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop) begin
        tx_rptr       <= tx_rptr + PTR_ONE;
        tx_byte       <= tx_mem[tx_rptr[AW-1:0]];
        tx_byte_valid <= 1'b1;
        gap_cnt       <= CNT_RELOAD;
      end else begin
        tx_byte_valid <= 1'b0;
        if (gap_cnt != '0)
          gap_cnt <= gap_cnt - CNT_ONE;
      end
      if (cmd_accept && !icb_cmd_read && hit_ctl)
        txen <= icb_cmd_wdata[0];
    end
  end

  // RX storage write port.
  always_ff @(posedge clk) begin
    if (rx_wr)
      rx_mem[rx_wptr[AW-1:0]] <= rx_byte;
  end

  // RX pointers and the sticky overflow flag for pushes that found no room.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_wr)
        rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)
        rx_rptr <= rx_rptr + PTR_ONE;
      if (rx_push && rx_full && !rx_pop)
        rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_icb_resp.sv
// tb/tb_uart_icb_resp.sv - scoreboard bench for uart_icb_resp with queue-based reference model
module tb_uart_icb_resp;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;
`ifdef UART_ICB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        tb_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr = 32'd0;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_wdata = 32'd0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b0;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        tx_byte_valid;
  logic [7:0]  tx_byte;
  logic        rx_push = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_overflow;

  uart_icb_resp #(.FIFO_DEPTH(DEPTH), .TX_GAP(GAP)) dut (
    .clk(tb_clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .tx_byte_valid(tx_byte_valid), .tx_byte(tx_byte),
    .rx_push(rx_push), .rx_byte(rx_byte), .rx_overflow(rx_overflow)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_txen, m_ovf;
  int         n_pass = 0, n_checks = 0;
  int         cyc = 0;
  bit         last_accept, lat_done, gap_check, have_last;
  int         last_tx = 0, tx_seen = 0, s0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference model of one accepted command, from the register map rules.
  function automatic void model_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd);
    rsp_t r;
    logic [11:0] a = addr[11:0];
    r.rdata = 32'd0;
    r.err   = 1'b0;
    r.acc   = cyc;
    if (a == 12'h000) begin
      if (rd) r.rdata = (tx_q.size() == DEPTH) ? 32'h8000_0000 : 32'd0;
      else if (tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
    end else if (a == 12'h004) begin
      if (rd && tx_q.size() >= 0 && rx_q.size() > 0) r.rdata = {24'h80_0000, rx_q.pop_front()};
    end else if (a == 12'h008) begin
      if (rd) r.rdata = {31'd0, m_txen};
      else m_txen = wd[0];
    end else begin
      r.err = ERR_EN;
    end
    exp_q.push_back(r);
  endfunction

  // Response monitor: latency on first sight, then data/err every presented cycle.
  always @(negedge tb_clk) begin
    if (rst_n && icb_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        if (!lat_done) begin
          chk("rsp_latency", cyc, exp_q[0].acc + 1);
          lat_done = 1'b1;
        end
        chk("rsp_rdata", icb_rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", {31'd0, icb_rsp_err}, {31'd0, exp_q[0].err});
        if (icb_rsp_ready) begin
          void'(exp_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  // TX monitor: order against the model FIFO, spacing against the pacing interval.
  always @(negedge tb_clk) begin
    if (rst_n && tx_byte_valid) begin
      tx_seen++;
      if (tx_q.size() == 0) chk("tx_unexpected", {24'd0, tx_byte}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_byte}, {24'd0, tx_q.pop_front()});
      if (gap_check && have_last) chk("tx_gap", cyc - last_tx, GAP);
      last_tx   = cyc;
      have_last = 1'b1;
    end
  end

  task automatic step();
    @(negedge tb_clk);
    last_accept = icb_cmd_valid && icb_cmd_ready && rst_n;
    if (last_accept) model_cmd(icb_cmd_read, icb_cmd_addr, icb_cmd_wdata);
    if (rx_push && rst_n) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(rx_byte);
      else m_ovf = 1'b1;
    end
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                       input bit prx, input logic [7:0] rb);
    bit got = 1'b0;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr; icb_cmd_wdata = wd;
    rx_push = prx; rx_byte = rb;
    for (int k = 0; k < 64 && !got; k++) begin
      step();
      got = last_accept;
      rx_push = 1'b0;
    end
    icb_cmd_valid = 1'b0;
    chk("issue_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    issue(1'b0, addr, wd, 1'b0, 8'd0);
  endtask

  task automatic rd(input logic [31:0] addr);
    issue(1'b1, addr, 32'd0, 1'b0, 8'd0);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_push = 1'b1; rx_byte = b;
    step();
    rx_push = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    chk("rsp_drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int op;
    logic [11:0] ua;

    // Reset state
    repeat (3) begin
      @(negedge tb_clk);
      chk("rst_tx_valid", {31'd0, tx_byte_valid}, 32'd0);
      @(posedge tb_clk);
      #1;
    end
    @(negedge tb_clk);
    chk("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
    chk("rst_rdata", icb_rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, icb_rsp_err}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    @(posedge tb_clk);
    #1;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    rd(32'h008);
    drain();

    // Paced TX of three bytes
    s0 = tx_seen;
    wr(32'h008, 32'd1);
    have_last = 1'b0;
    gap_check = 1'b1;
    wr(32'h000, 32'h4E);
    wr(32'h000, 32'h55);
    wr(32'h000, 32'h43);
    idle(3 * GAP + 8);
    chk("t2_tx_count", tx_seen - s0, 3);
    wr(32'h008, 32'd0);

    // Nine writes with drain disabled: ninth dropped, full flag reported
    s0 = tx_seen;
    for (int i = 0; i < 9; i++) wr(32'h000, 32'hC0 + i);
    rd(32'h000);
    idle(20);
    chk("t3_hold", tx_seen - s0, 0);
    have_last = 1'b0;
    wr(32'h008, 32'd1);
    idle(DEPTH * GAP + 20);
    chk("t3_count", tx_seen - s0, 8);
    chk("t3_empty", tx_q.size(), 0);
    wr(32'h008, 32'd0);
    drain();

    // RX single byte then empty read
    push_rx(8'hA5);
    rd(32'h004);
    rd(32'h004);
    drain();

    // RX overflow, then push concurrent with a pop on a full FIFO
    for (int i = 0; i < 9; i++) push_rx(8'h10 + 8'(i));
    chk("t5_ovf_set", {31'd0, rx_overflow}, 32'd1);
    issue(1'b1, 32'h004, 32'd0, 1'b1, 8'hEE);
    chk("t5_rx_level", rx_q.size(), DEPTH);
    for (int i = 0; i < DEPTH + 1; i++) rd(32'h004);
    chk("t5_ovf_sticky", {31'd0, rx_overflow}, 32'd1);
    drain();

    // Response stall with a second command pending
    icb_rsp_ready = 1'b0;
    rd(32'h008);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
      chk("t6_no_accept", {31'd0, last_accept}, 32'd0);
    end
    icb_rsp_ready = 1'b1;
    step();
    chk("t6_accept", {31'd0, last_accept}, 32'd1);
    icb_cmd_valid = 1'b0;
    drain();

    // Randomized traffic with drain disabled
    for (int it = 0; it < 400; it++) begin
      if (!icb_cmd_valid && $urandom_range(0, 1) == 1) begin
        r  = $urandom;
        op = $urandom_range(0, 7);
        icb_cmd_valid = 1'b1;
        icb_cmd_wdata = $urandom;
        case (op)
          0: begin icb_cmd_read = 1'b0; icb_cmd_addr = {r[31:12], 12'h000}; end
          1: begin icb_cmd_read = 1'b1; icb_cmd_addr = {r[31:12], 12'h000}; end
          2, 3: begin icb_cmd_read = 1'b1; icb_cmd_addr = {r[31:12], 12'h004}; end
          4: begin icb_cmd_read = 1'b0; icb_cmd_addr = {r[31:12], 12'h008};
                   icb_cmd_wdata[0] = 1'b0; end
          5: begin icb_cmd_read = 1'b1; icb_cmd_addr = {r[31:12], 12'h008}; end
          6: begin icb_cmd_read = 1'b0; icb_cmd_addr = {r[31:12], 12'h004}; end
          default: begin
            case (r[2:1])
              2'd0: ua = 12'h00C;
              2'd1: ua = 12'h010;
              2'd2: ua = 12'hFFC;
              default: ua = 12'h800;
            endcase
            icb_cmd_read = r[0];
            icb_cmd_addr = {r[31:12], ua};
          end
        endcase
      end
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
      rx_push = ($urandom_range(0, 2) == 0);
      rx_byte = 8'($urandom);
      step();
      if (last_accept) icb_cmd_valid = 1'b0;
    end
    rx_push = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b1;
    drain();
    chk("t7_ovf", {31'd0, rx_overflow}, {31'd0, m_ovf});
    have_last = 1'b0;
    wr(32'h008, 32'd1);
    idle(DEPTH * GAP + 20);
    chk("t7_tx_flush", tx_q.size(), 0);
    wr(32'h008, 32'd0);
    drain();

    // Reset with a response pending and data in both FIFOs
    push_rx(8'h77);
    push_rx(8'h78);
    wr(32'h000, 32'h99);
    rd(32'h004);
    icb_rsp_ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("t8_rsp_dropped", {31'd0, icb_rsp_valid}, 32'd0);
    exp_q.delete();
    lat_done = 1'b0;
    rx_q.delete();
    tx_q.delete();
    m_txen = 1'b0;
    m_ovf = 1'b0;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    chk("t8_ovf_clear", {31'd0, rx_overflow}, 32'd0);
    rd(32'h004);
    rd(32'h000);
    rd(32'h008);
    s0 = tx_seen;
    wr(32'h008, 32'd1);
    idle(40);
    chk("t8_tx_flushed", tx_seen - s0, 0);
    drain();

    chk("end_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
